// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and default width for the sequential divider
package div_pkg;
  localparam int DEFAULT_N = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division iteration (shift in a bit, compare, subtract)
module div_step
  import div_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] rem_o,
  output logic         q_o
);
  logic [N:0] t, diff;
  assign t = {rem_i, bit_i};
  assign diff = t - {1'b0, divisor_i};
  assign q_o = t >= {1'b0, divisor_i};
  // the kept value is always below the divisor, so it fits back into N bits
  assign rem_o = N'(q_o ? diff : t);
endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: 2N/N unsigned restoring divider, one quotient bit per cycle
module sequential_divider
  import div_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);
  localparam int CW = $clog2(N + 1);
  state_e state_q, state_d;
  logic [N-1:0] div_q, div_d, rem_q, rem_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, ovf_q, ovf_d;
  logic [N-1:0] step_rem;
  logic step_bit;
  div_step #(.N(N)) u_step (
    .rem_i(rem_q),
    .bit_i(lo_q[N-1]),
    .divisor_i(div_q),
    .rem_o(step_rem),
    .q_o(step_bit)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  // lo_q shifts out dividend bits MSB-first while quotient bits shift in, ending as the quotient
  assign quotient = lo_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow = ovf_q;
  // next-state and datapath update for accept, iterate and handshake
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    rem_d = rem_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        div_d = divisor;
        dbz_d = divisor == '0;
        ovf_d = divisor != '0 && dividend[2*N-1:N] >= divisor;
        cnt_d = '0;
        if (divisor == '0) begin
          state_d = DONE;
          lo_d = '1;
          rem_d = dividend[N-1:0];
        end else if (dividend[2*N-1:N] >= divisor) begin
          state_d = DONE;
          lo_d = '1;
          rem_d = '0;
        end else begin
          state_d = RUN;
          lo_d = dividend[N-1:0];
          rem_d = dividend[2*N-1:N];
        end
      end
      RUN: begin
        rem_d = step_rem;
        lo_d = {lo_q[N-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(N - 1) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      div_q <= '0;
      rem_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      rem_q <= rem_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: scoreboard bench with directed vectors, reset and back-pressure cases
module tb_sequential_divider;
  localparam int N = 16;
  typedef struct {
    logic [31:0] dd;
    logic [15:0] dv, q, r;
    logic dbz, ovf;
    int lat, vcyc;
  } exp_t;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dividend;
  logic [15:0] divisor, quotient, remainder;
  logic div_by_zero, overflow;
  logic rdy_rand, rdy_force, ov_prev;
  int n_cmp, n_fail, ncyc;
  exp_t pend, e_out;
  exp_t sb[$];

  sequential_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, ncyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, ncyc);
  endtask

  function automatic exp_t model(input logic [31:0] dd, input logic [15:0] dv);
    exp_t m;
    m.dd = dd; m.dv = dv; m.vcyc = 0;
    m.dbz = dv == 0;
    m.ovf = dv != 0 && dd[31:16] >= dv;
    if (m.dbz) begin m.q = 16'hFFFF; m.r = dd[15:0]; m.lat = 1; end
    else if (m.ovf) begin m.q = 16'hFFFF; m.r = 0; m.lat = 1; end
    else begin m.q = 16'(dd / 32'(dv)); m.r = 16'(dd % 32'(dv)); m.lat = N + 1; end
    return m;
  endfunction

  function automatic exp_t hand(input logic [31:0] dd, input logic [15:0] dv, input logic [15:0] q,
                                input logic [15:0] r, input logic dbz, input logic ovf, input int lat);
    exp_t m;
    m.dd = dd; m.dv = dv; m.q = q; m.r = r; m.dbz = dbz; m.ovf = ovf; m.lat = lat; m.vcyc = 0;
    return m;
  endfunction

  // out_ready is updated 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // monitor: captures accepts into the scoreboard, checks latency and consumed results
  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(pend);
        sb[$].vcyc = ncyc + pend.lat;
      end
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) fail("unexpected_valid");
        else chk("latency", 64'(ncyc), 64'(sb[0].vcyc));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail("unexpected_result");
        else begin
          e_out = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e_out.q));
          chk("remainder", 64'(remainder), 64'(e_out.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e_out.dbz));
          chk("overflow", 64'(overflow), 64'(e_out.ovf));
          if (!e_out.dbz && !e_out.ovf) begin
            chk("identity", 64'(quotient) * 64'(e_out.dv) + 64'(remainder), 64'(e_out.dd));
            chk("rem_lt_div", 64'(remainder < e_out.dv), 64'd1);
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  // call at posedge+1; holds the pair until accepted, then scrambles the ignored inputs
  task automatic drive(input exp_t e);
    int b;
    pend = e;
    dividend = e.dd;
    divisor = e.dv;
    in_valid = 1;
    b = 0;
    while (!in_ready && b < 200) begin @(posedge clk); #1; b++; end
    if (b >= 200) fail("accept_wait");
    @(posedge clk); #1;
    in_valid = 0;
    dividend = $urandom;
    divisor = 16'($urandom);
  endtask

  task automatic drain;
    int b;
    b = 0;
    while ((sb.size() != 0 || !in_ready) && b < 1000) begin @(posedge clk); #1; b++; end
    if (b >= 1000) fail("drain");
  endtask

  initial begin
    logic [15:0] dv, hi;
    int cat, b;
    n_cmp = 0; n_fail = 0; ncyc = 0; ov_prev = 0;
    in_valid = 0; dividend = 0; divisor = 0; out_ready = 0;
    rdy_rand = 0; rdy_force = 1;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    drive(hand(32'd100, 16'd7, 16'd14, 16'd2, 0, 0, 17)); drain();
    drive(hand(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 17)); drain();
    drive(hand(32'h00001234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 1)); drain();
    drive(hand(32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 0, 1, 1)); drain();
    drive(hand(32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 1)); drain();
    drive(hand(32'h0000FFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 17)); drain();
    drive(hand(32'h12345678, 16'h9ABC, 16'h1E1E, 16'h2C70, 0, 0, 17)); drain();
    drive(hand(32'd5, 16'd10, 16'd0, 16'd5, 0, 0, 17)); drain();
    chk("idle_hold_quotient", 64'(quotient), 64'd0);
    chk("idle_hold_remainder", 64'(remainder), 64'd5);
    rdy_force = 0;
    drive(hand(32'd100, 16'd7, 16'd14, 16'd2, 0, 0, 17));
    b = 0;
    while (!out_valid && b < 100) begin @(posedge clk); #1; b++; end
    if (b >= 100) fail("bp_wait");
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_quotient", 64'(quotient), 64'd14);
      chk("bp_remainder", 64'(remainder), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    rdy_force = 1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_hold", 64'(quotient), 64'd14);
    drive(hand(32'h12345678, 16'h9ABC, 16'h1E1E, 16'h2C70, 0, 0, 17));
    repeat (7) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_quotient", 64'(quotient), 64'd0);
    chk("mid_rst_remainder", 64'(remainder), 64'd0);
    chk("mid_rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    sb.delete();
    #1 rst_n = 1;
    @(posedge clk); #1;
    drive(hand(32'd100, 16'd7, 16'd14, 16'd2, 0, 0, 17)); drain();
    rdy_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      cat = $urandom_range(0, 9);
      dv = 16'($urandom_range(1, 65535));
      if (cat == 0) drive(model($urandom, 16'h0000));
      else if (cat == 1) begin
        hi = 16'($urandom_range(int'(dv), 65535));
        drive(model({hi, 16'($urandom)}, dv));
      end else begin
        hi = 16'($urandom_range(0, int'(dv) - 1));
        drive(model({hi, 16'($urandom)}, dv));
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
